instr_prefetch: RTL and testbench

Instruction prefetch unit sitting directly upstream of the boot ROM's Avalon read port. It acts as an Avalon read master with fixed 1-cycle read latency, issuing sequential word reads from a fetch PC. Returned words are buffered in a small FIFO tagged with their PC and handed to the core over a valid/ready interface. A redirect input (jump, branch or trap) flushes all buffered and in-flight fetches and restarts fetch at the new PC.

---
 rtl/instr_prefetch.sv | 162 ++++++++++++++++
 tb/tb_instr_prefetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: Avalon read master (fixed 1-cycle read latency)
// that streams sequential instruction words into a small PC-tagged FIFO and
// hands them to the core over valid/ready. A redirect flushes buffered and
// in-flight fetches and restarts fetch at the new PC.
module instr_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'hFFC0_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  // Avalon read master
  output logic [31:0] o_AV_Address,
  output logic        o_AV_Read,
  input  logic        i_AV_WaitRequest,
  input  logic [31:0] i_AV_ReadData,
  // Instruction stream to the core
  output logic [31:0] o_Instr,
  output logic [31:0] o_InstrPC,
  output logic        o_InstrValid,
  input  logic        i_InstrReady,
  // Control-flow redirect
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_CRED = (CNT_W + 1)'(FIFO_DEPTH);

  // The pointer wrap and credit arithmetic assume a power-of-two depth >= 2.
  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instr_prefetch: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      r_FetchPC;
  logic [31:0]      r_PendPC;
  logic             r_Pending;
  logic [PTR_W-1:0] r_WrPtr;
  logic [PTR_W-1:0] r_RdPtr;
  logic [CNT_W-1:0] r_Count;
  logic [31:0]      r_MemInstr [FIFO_DEPTH];
  logic [31:0]      r_MemPC    [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [CNT_W:0]   w_Credit;
  logic             w_Read;
  logic             w_Accept;
  logic             w_Push;
  logic             w_Pop;
  logic [PTR_W-1:0] w_WrPtrNext;
  logic [PTR_W-1:0] w_RdPtrNext;
  logic [CNT_W-1:0] w_CountNext;
  logic [31:0]      w_RedirectPC;
  logic             w_unused;

  // Buffered entries plus the read in flight must leave room for its data, so
  // the issue decision depends only on registered state (and reset).
  assign w_Credit = {1'b0, r_Count} + {{CNT_W{1'b0}}, r_Pending};
  assign w_Read   = i_Rst_n & (w_Credit < DEPTH_CRED);
  assign w_Accept = w_Read & ~i_AV_WaitRequest;

  // Read data is valid exactly one cycle after acceptance.
  assign w_Push = r_Pending;
  assign w_Pop  = (r_Count != '0) & i_InstrReady;

  assign w_WrPtrNext = (r_WrPtr == LAST_PTR) ? '0 : r_WrPtr + PTR_W'(1);
  assign w_RdPtrNext = (r_RdPtr == LAST_PTR) ? '0 : r_RdPtr + PTR_W'(1);

  // Instruction fetches are word aligned; the low address bits are dropped.
  assign w_RedirectPC = {i_RedirectPC[31:2], 2'b00};
  assign w_unused     = &{1'b0, i_RedirectPC[1:0]};

  // Occupancy after this cycle's push/pop (redirect handled in the register).
  always_comb begin
    // NOTE: default assignment first so every path assigns the signal and no
    // latch is inferred.
    w_CountNext = r_Count;
    case ({w_Push, w_Pop})
      2'b10:   w_CountNext = r_Count + CNT_W'(1);
      2'b01:   w_CountNext = r_Count - CNT_W'(1);
      default: w_CountNext = r_Count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch address, in-flight tracking and FIFO pointers/count
  // ---------------------------------------------------------------------------
  // Fetch control: reset, then redirect, then normal issue/push/pop.
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (!i_Rst_n) begin
      r_FetchPC <= RESET_PC;
      r_PendPC  <= '0;
      r_Pending <= 1'b0;
      r_WrPtr   <= '0;
      r_RdPtr   <= '0;
      r_Count   <= '0;
    end else if (i_Redirect) begin
      // A read accepted now is a legal bus cycle, but clearing r_Pending
      // makes its returning data be ignored; any response arriving this
      // cycle and any simultaneous pop are dropped as well.
      r_FetchPC <= w_RedirectPC;
      r_Pending <= 1'b0;
      r_WrPtr   <= '0;
      r_RdPtr   <= '0;
      r_Count   <= '0;
    end else begin
      if (w_Accept) begin
        r_FetchPC <= r_FetchPC + 32'd4;
        r_PendPC  <= r_FetchPC;
        r_Pending <= 1'b1;
      end else begin
        r_Pending <= 1'b0;
      end
      if (w_Push) begin
        r_WrPtr <= w_WrPtrNext;
      end
      if (w_Pop) begin
        r_RdPtr <= w_RdPtrNext;
      end
      r_Count <= w_CountNext;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // Capture returning read data with its PC at the write pointer.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      // NOTE: the storage is cleared on reset because the head entry drives
      // o_Instr/o_InstrPC directly and they must read zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_MemInstr[i] <= '0;
        r_MemPC[i]    <= '0;
      end
    end else if (!i_Redirect && w_Push) begin
      r_MemInstr[r_WrPtr] <= i_AV_ReadData;
      r_MemPC[r_WrPtr]    <= r_PendPC;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_AV_Address = r_FetchPC;
  assign o_AV_Read    = w_Read;
  assign o_Instr      = r_MemInstr[r_RdPtr];
  assign o_InstrPC    = r_MemPC[r_RdPtr];
  assign o_InstrValid = (r_Count != '0);

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed testbench for instr_prefetch with a 1-cycle-latency ROM responder.
module tb_instr_prefetch;

  localparam logic [31:0] BASE = 32'hFFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] av_addr;
  logic        av_read;
  logic        av_wait;
  logic [31:0] av_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redir;
  logic [31:0] redir_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_prefetch #(.RESET_PC(BASE), .FIFO_DEPTH(4)) dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .o_AV_Address     (av_addr),
    .o_AV_Read        (av_read),
    .i_AV_WaitRequest (av_wait),
    .i_AV_ReadData    (av_rdata),
    .o_Instr          (instr),
    .o_InstrPC        (instr_pc),
    .o_InstrValid     (instr_valid),
    .i_InstrReady     (instr_ready),
    .i_Redirect       (redir),
    .i_RedirectPC     (redir_pc)
  );

  // ROM contents: four boot words, then an address-derived pattern.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    case (idx)
      32'd0:   rom_word = 32'hff010113;
      32'd1:   rom_word = 32'h00112623;
      32'd2:   rom_word = 32'hc0400117;
      32'd3:   rom_word = 32'h1f810113;
      default: rom_word = {a[15:0] ^ 16'h5A5A, a[31:16]};
    endcase
  endfunction

  // ROM slave: data for an accepted read appears in the following cycle;
  // otherwise garbage so stale captures are visible.
  always @(posedge clk) begin
    av_rdata <= (av_read && !av_wait) ? rom_word(av_addr) : 32'hBAD0_BAD0;
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    av_wait     = 1'b0;
    instr_ready = 1'b0;
    redir       = 1'b0;
    redir_pc    = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (av_read !== 1'b0) begin n_errors++; $display("FAIL reset_read: got %b exp 0", av_read); end
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h exp 0", instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h exp 0", instr_pc); end
    n_checks++; if (av_addr !== BASE) begin n_errors++; $display("FAIL reset_addr: got %h exp %h", av_addr, BASE); end
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      rst_n = 1'b1; instr_ready = 1'b1; #1;
      n_checks++; if (av_read !== 1'b1) begin n_errors++; $display("FAIL stream_read c%0d: got %b exp 1", c, av_read); end
      n_checks++; if (av_addr !== BASE + 32'(4 * c)) begin n_errors++; $display("FAIL stream_addr c%0d: got %h exp %h", c, av_addr, BASE + 32'(4 * c)); end
      n_checks++; if (instr_valid !== (c >= 2)) begin n_errors++; $display("FAIL stream_valid c%0d: got %b exp %b", c, instr_valid, c >= 2); end
      if (c >= 2) begin
        ep = BASE + 32'(4 * (c - 2));
        n_checks++; if (instr_pc !== ep) begin n_errors++; $display("FAIL stream_pc c%0d: got %h exp %h", c, instr_pc, ep); end
        n_checks++; if (instr !== rom_word(ep)) begin n_errors++; $display("FAIL stream_instr c%0d: got %h exp %h", c, instr, rom_word(ep)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic exp_read;
    logic [31:0] ea;
    acc = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      rst_n = 1'b1; instr_ready = (c == 8); #1;
      if (av_read && !av_wait) acc++;
      exp_read = (c <= 3) || (c == 9);
      n_checks++; if (av_read !== exp_read) begin n_errors++; $display("FAIL bp_read c%0d: got %b exp %b", c, av_read, exp_read); end
      if (exp_read) begin
        ea = (c == 9) ? BASE + 32'h10 : BASE + 32'(4 * c);
        n_checks++; if (av_addr !== ea) begin n_errors++; $display("FAIL bp_addr c%0d: got %h exp %h", c, av_addr, ea); end
      end
      if (c == 5) begin
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== BASE) begin n_errors++; $display("FAIL bp_head_full: got %b/%h exp 1/%h", instr_valid, instr_pc, BASE); end
      end
      if (c == 9 || c == 11) begin
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== BASE + 32'h4) begin n_errors++; $display("FAIL bp_head_after_pop c%0d: got %b/%h exp 1/%h", c, instr_valid, instr_pc, BASE + 32'h4); end
      end
    end
    n_checks++; if (acc !== 5) begin n_errors++; $display("FAIL bp_accept_count: got %0d exp 5", acc); end
  endtask

  task automatic test_waitrequest();
    int pops;
    logic [31:0] ep;
    pops = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      rst_n = 1'b1; instr_ready = 1'b1; av_wait = (c >= 1 && c <= 3); #1;
      if (c >= 1 && c <= 3) begin
        n_checks++; if (av_read !== 1'b1 || av_addr !== BASE + 32'h4) begin n_errors++; $display("FAIL wait_hold c%0d: got %b/%h exp 1/%h", c, av_read, av_addr, BASE + 32'h4); end
      end
      if (instr_valid) begin
        ep = BASE + 32'(4 * pops);
        n_checks++; if (instr_pc !== ep) begin n_errors++; $display("FAIL wait_pc c%0d: got %h exp %h", c, instr_pc, ep); end
        n_checks++; if (instr !== rom_word(ep)) begin n_errors++; $display("FAIL wait_instr c%0d: got %h exp %h", c, instr, rom_word(ep)); end
        pops++;
      end
    end
    av_wait = 1'b0;
    n_checks++; if (pops !== 7) begin n_errors++; $display("FAIL wait_pop_count: got %0d exp 7", pops); end
  endtask

  task automatic test_redirect();
    logic [31:0] ep;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      rst_n = 1'b1; instr_ready = (c >= 5); redir = (c == 4); redir_pc = 32'hFFC0_0133; #1;
      if (c == 4) begin
        n_checks++; if (av_read !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== BASE) begin n_errors++; $display("FAIL redir_pre: got rd %b v %b pc %h exp rd 0 v 1 pc %h", av_read, instr_valid, instr_pc, BASE); end
      end
      if (c == 5) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL redir_flush: got %b exp 0", instr_valid); end
        n_checks++; if (av_read !== 1'b1 || av_addr !== 32'hFFC0_0130) begin n_errors++; $display("FAIL redir_addr: got %b/%h exp 1/ffc00130", av_read, av_addr); end
      end
      if (c == 6) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL redir_stale: got %b exp 0", instr_valid); end
      end
      if (c >= 7) begin
        ep = 32'hFFC0_0130 + 32'(4 * (c - 7));
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== ep) begin n_errors++; $display("FAIL redir_pc c%0d: got %b/%h exp 1/%h", c, instr_valid, instr_pc, ep); end
        n_checks++; if (instr !== rom_word(ep)) begin n_errors++; $display("FAIL redir_instr c%0d: got %h exp %h", c, instr, rom_word(ep)); end
      end
    end
    redir = 1'b0;
  endtask

  task automatic test_redirect_pop();
    logic [31:0] ep;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      rst_n = 1'b1; instr_ready = 1'b1; redir = (c == 2); redir_pc = BASE + 32'h40; #1;
      if (c == 2) begin
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== BASE) begin n_errors++; $display("FAIL rpop_pre: got %b/%h exp 1/%h", instr_valid, instr_pc, BASE); end
      end
      if (c == 3) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rpop_empty: got %b exp 0", instr_valid); end
        n_checks++; if (av_read !== 1'b1 || av_addr !== BASE + 32'h40) begin n_errors++; $display("FAIL rpop_addr: got %b/%h exp 1/%h", av_read, av_addr, BASE + 32'h40); end
      end
      if (c == 4) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rpop_underflow: got %b exp 0", instr_valid); end
      end
      if (c >= 5) begin
        ep = BASE + 32'h40 + 32'(4 * (c - 5));
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== ep) begin n_errors++; $display("FAIL rpop_pc c%0d: got %b/%h exp 1/%h", c, instr_valid, instr_pc, ep); end
      end
    end
    redir = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ep;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      rst_n = (c != 6); instr_ready = (c >= 7); #1;
      if (c == 5) begin
        n_checks++; if (instr_valid !== 1'b1 || av_read !== 1'b0) begin n_errors++; $display("FAIL rmid_full: got v %b rd %b exp v 1 rd 0", instr_valid, av_read); end
      end
      if (c == 6) begin
        n_checks++; if (av_read !== 1'b0) begin n_errors++; $display("FAIL rmid_read_low: got %b exp 0", av_read); end
      end
      if (c == 7) begin
        n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin n_errors++; $display("FAIL rmid_outputs: got v %b i %h pc %h exp 0/0/0", instr_valid, instr, instr_pc); end
        n_checks++; if (av_read !== 1'b1 || av_addr !== BASE) begin n_errors++; $display("FAIL rmid_restart: got %b/%h exp 1/%h", av_read, av_addr, BASE); end
      end
      if (c == 8) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_valid_c8: got %b exp 0", instr_valid); end
      end
      if (c >= 9) begin
        ep = BASE + 32'(4 * (c - 9));
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== ep) begin n_errors++; $display("FAIL rmid_pc c%0d: got %b/%h exp 1/%h", c, instr_valid, instr_pc, ep); end
        n_checks++; if (instr !== rom_word(ep)) begin n_errors++; $display("FAIL rmid_instr c%0d: got %h exp %h", c, instr, rom_word(ep)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_waitrequest();
    test_redirect();
    test_redirect_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
